// File: rtl/rx_packet_controller.sv
// Receive-side packet sequencer for the USB RX path.
// Starts the bit timer and byte counter when a packet begins, checks the
// SYNC byte, strobes each received data byte into the RX FIFO, and flags
// SYNC, partial-byte and over-length errors.
module rx_packet_controller #(
  parameter logic [7:0]  SYNC_BYTE = 8'h80,
  parameter int unsigned MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_done,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       enable_timer,
  output logic       byte_clear,
  output logic       w_enable,
  output logic       r_error
);

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    SYNC,
    CHK_SYNC,
    RCV,
    STORE,
    ERR_WAIT,
    EOP_WAIT,
    EOP_WAIT_ERR
  } state_t;

  state_t     state, next_state;
  logic       mid_byte;
  logic [7:0] byte_cnt;
  logic       over_len;

  logic rcving_d, enable_timer_d, byte_clear_d, w_enable_d, r_error_d;

  // EOP is only meaningful on a bit-sample strobe.
  logic eop_bit;
  assign eop_bit = eop & shift_enable;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; byte_done outranks a coincident EOP strobe.
  // NOTE: the default assignment first keeps every path assigned, so no
  // latch is inferred for next_state.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:         if (d_edge) next_state = CLEAR;
      CLEAR:        next_state = SYNC;
      SYNC: begin
        if (byte_done)    next_state = CHK_SYNC;
        else if (eop_bit) next_state = EOP_WAIT_ERR;
      end
      CHK_SYNC:     next_state = (rcv_data == SYNC_BYTE) ? RCV : ERR_WAIT;
      RCV: begin
        if (byte_done)    next_state = STORE;
        else if (eop_bit) next_state = mid_byte ? EOP_WAIT_ERR : EOP_WAIT;
      end
      STORE:        next_state = over_len ? ERR_WAIT : RCV;
      ERR_WAIT:     if (eop_bit) next_state = EOP_WAIT_ERR;
      EOP_WAIT,
      EOP_WAIT_ERR: if (shift_enable && !eop) next_state = IDLE;
      default:      next_state = IDLE;
    endcase
  end

  // Output decode of the state being entered, so the registered outputs
  // line up with the state register; IDLE keeps the error flag sticky.
  always_comb begin
    rcving_d       = 1'b0;
    enable_timer_d = 1'b0;
    byte_clear_d   = 1'b0;
    w_enable_d     = 1'b0;
    r_error_d      = 1'b0;
    unique case (next_state)
      IDLE:         r_error_d = r_error;
      CLEAR: begin
        byte_clear_d = 1'b1;
        rcving_d     = 1'b1;
      end
      SYNC, CHK_SYNC, RCV, EOP_WAIT: begin
        rcving_d       = 1'b1;
        enable_timer_d = 1'b1;
      end
      STORE: begin
        rcving_d       = 1'b1;
        enable_timer_d = 1'b1;
        w_enable_d     = 1'b1;
      end
      ERR_WAIT, EOP_WAIT_ERR: begin
        rcving_d       = 1'b1;
        enable_timer_d = 1'b1;
        r_error_d      = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcving       <= 1'b0;
      enable_timer <= 1'b0;
      byte_clear   <= 1'b0;
      w_enable     <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      rcving       <= rcving_d;
      enable_timer <= enable_timer_d;
      byte_clear   <= byte_clear_d;
      w_enable     <= w_enable_d;
      r_error      <= r_error_d;
    end
  end

  // Partial-byte tracker: a bit has been shifted since the last byte boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        mid_byte <= 1'b0;
    else if (byte_done)             mid_byte <= 1'b0;
    else if (shift_enable && !eop)  mid_byte <= 1'b1;
  end

  // Data byte count; over_len marks that the byte now being stored is
  // number MAX_BYTES+1, kept as a flag so MAX_BYTES=255 needs no 9th bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      over_len <= 1'b0;
    end else if (state == CLEAR) begin
      byte_cnt <= '0;
      over_len <= 1'b0;
    end else if (state == RCV && next_state == STORE) begin
      byte_cnt <= byte_cnt + 8'd1;
      over_len <= (byte_cnt == 8'(MAX_BYTES));
    end
  end

endmodule

// File: tb/tb_rx_packet_controller.sv
// Directed bench for rx_packet_controller (MAX_BYTES overridden to 4).
module tb_rx_packet_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_edge, eop, shift_enable, byte_done;
  logic [7:0] rcv_data;
  logic       rcving, enable_timer, byte_clear, w_enable, r_error;

  int tests = 0;
  int fails = 0;
  int wcount = 0;
  logic [7:0] wq[$];

  rx_packet_controller #(.SYNC_BYTE(8'h80), .MAX_BYTES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .d_edge       (d_edge),
    .eop          (eop),
    .shift_enable (shift_enable),
    .byte_done    (byte_done),
    .rcv_data     (rcv_data),
    .rcving       (rcving),
    .enable_timer (enable_timer),
    .byte_clear   (byte_clear),
    .w_enable     (w_enable),
    .r_error      (r_error)
  );

  always #5 clk = ~clk;

  // Record every FIFO write strobe and the byte presented with it.
  always @(negedge clk) begin
    if (w_enable === 1'b1) begin
      wcount++;
      wq.push_back(rcv_data);
    end
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs packed as {rcving, enable_timer, byte_clear, w_enable, r_error}.
  function automatic logic [7:0] outs();
    return {3'b000, rcving, enable_timer, byte_clear, w_enable, r_error};
  endfunction

  // Apply one cycle of inputs, then sample just after the edge.
  task automatic step(input logic de, input logic e, input logic se, input logic bd);
    d_edge = de; eop = e; shift_enable = se; byte_done = bd;
    @(posedge clk); #1;
    d_edge = 0; eop = 0; shift_enable = 0; byte_done = 0;
  endtask

  // n bit strobes with a gap cycle after each.
  task automatic send_bits(input int n, input logic [7:0] data);
    rcv_data = data;
    for (int i = 0; i < n; i++) begin
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
  endtask

  // Packet start through SYNC check; leaves the DUT in RCV.
  task automatic start_packet();
    step(1, 0, 0, 0);       // -> CLEAR
    step(0, 0, 0, 0);       // -> SYNC
    send_bits(8, 8'h80);
    step(0, 0, 0, 1);       // -> CHK_SYNC
    step(0, 0, 0, 0);       // -> RCV
  endtask

  initial begin
    rst = 1; d_edge = 0; eop = 0; shift_enable = 0; byte_done = 0; rcv_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs(), 8'h00);
    rst = 0;
    step(0, 0, 0, 0);
    check("idle_outs", outs(), 8'h00);

    // ---------------- Good packet ----------------
    step(1, 0, 0, 0);
    check("good_clear", outs(), 8'b10100);
    step(0, 0, 0, 0);
    check("good_sync", outs(), 8'b11000);
    send_bits(8, 8'h80);
    step(0, 0, 0, 1);
    check("good_chk_sync", outs(), 8'b11000);
    step(0, 0, 0, 0);
    check("good_rcv", outs(), 8'b11000);
    send_bits(8, 8'hA5);
    step(0, 0, 0, 1);
    check("good_store1", outs(), 8'b11010);
    step(0, 0, 0, 0);
    check("good_back_rcv1", outs(), 8'b11000);
    send_bits(8, 8'h3C);
    step(0, 0, 0, 1);
    check("good_store2", outs(), 8'b11010);
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    check("good_eop_wait", outs(), 8'b11000);
    step(0, 1, 0, 0);
    check("good_eop_hold", outs(), 8'b11000);
    step(0, 0, 1, 0);
    check("good_idle", outs(), 8'h00);
    check("good_wcount", 8'(wcount), 8'd2);
    check("good_byte0", wq[0], 8'hA5);
    check("good_byte1", wq[1], 8'h3C);

    // ---------------- Bad SYNC ----------------
    wcount = 0;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    send_bits(8, 8'h81);
    step(0, 0, 0, 1);       // CHK_SYNC
    step(0, 0, 0, 0);       // ERR_WAIT
    check("badsync_err_wait", outs(), 8'b11001);
    send_bits(8, 8'hFF);
    check("badsync_still_err", outs(), 8'b11001);
    step(0, 1, 1, 0);
    check("badsync_eop_wait_err", outs(), 8'b11001);
    step(0, 0, 1, 0);
    check("badsync_idle_sticky", outs(), 8'b00001);
    step(0, 0, 0, 0);
    check("badsync_idle_hold", outs(), 8'b00001);
    check("badsync_no_write", 8'(wcount), 8'd0);

    // ---------------- Partial byte (also clears the sticky error) ----------------
    step(1, 0, 0, 0);
    check("partial_clear_err", outs(), 8'b10100);
    step(0, 0, 0, 0);
    send_bits(8, 8'h80);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("partial_rcv", outs(), 8'b11000);
    send_bits(8, 8'h11);
    step(0, 0, 0, 1);
    check("partial_store", outs(), 8'b11010);
    step(0, 0, 0, 0);
    send_bits(3, 8'h03);
    step(0, 1, 1, 0);
    check("partial_eop_err", outs(), 8'b11001);
    step(0, 0, 1, 0);
    check("partial_idle", outs(), 8'b00001);
    check("partial_wcount", 8'(wcount), 8'd1);

    // ---------------- Overlength (MAX_BYTES=4, 5 bytes) ----------------
    wcount = 0;
    start_packet();
    check("over_clear_err", outs(), 8'b11000);
    for (int b = 0; b < 5; b++) begin
      send_bits(8, 8'(8'h20 + b));
      step(0, 0, 0, 1);
      check($sformatf("over_store%0d", b), outs(), 8'b11010);
      step(0, 0, 0, 0);
      check($sformatf("over_after%0d", b), outs(), (b == 4) ? 8'b11001 : 8'b11000);
    end
    send_bits(8, 8'h99);
    step(0, 0, 0, 1);
    check("over_ignored_byte", outs(), 8'b11001);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    check("over_idle", outs(), 8'b00001);
    check("over_wcount", 8'(wcount), 8'd5);

    // ---------------- Simultaneous events ----------------
    wcount = 0;
    start_packet();
    step(1, 0, 0, 0);
    check("sim_dedge_ignored", outs(), 8'b11000);
    send_bits(7, 8'h5A);
    step(0, 1, 1, 1);       // byte_done with EOP strobe
    check("sim_store_first", outs(), 8'b11010);
    step(0, 1, 0, 0);
    check("sim_back_rcv", outs(), 8'b11000);
    step(0, 1, 1, 0);
    check("sim_eop_wait_good", outs(), 8'b11000);
    step(0, 0, 1, 0);
    check("sim_idle", outs(), 8'h00);
    check("sim_wcount", 8'(wcount), 8'd1);

    // ---------------- Reset mid-packet ----------------
    start_packet();
    send_bits(8, 8'h77);
    step(0, 0, 0, 1);
    check("rst_pre_store", outs(), 8'b11010);
    #1 rst = 1;
    #1;
    check("rst_async_clear", outs(), 8'h00);
    @(posedge clk); #1;
    rst = 0;
    step(0, 0, 0, 1);
    check("rst_idle_after", outs(), 8'h00);
    step(1, 0, 0, 0);
    check("rst_restart", outs(), 8'b10100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
